// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // Memory rw pin encoding
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Burst counter width; a one-cycle burst still needs a one-bit counter
  function automatic int burst_cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_fsm.sv
// Round-robin ownership FSM with bounded burst length for two memory masters.
module rr_arb_fsm
  import mem_bus_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam int CNT_W = burst_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             contested;

  // Next owner, round-robin pointer and burst length under contention
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    contested   = ((state_q == OWN0) && req1) || ((state_q == OWN1) && req0);

    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                             state_d = req1 ? OWN1 : IDLE;
        else if (req1 && burst_cnt_q == CNT_LAST) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                             state_d = req0 ? OWN0 : IDLE;
        else if (req0 && burst_cnt_q == CNT_LAST) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)
      burst_cnt_d = '0;
    else if (contested && burst_cnt_q != CNT_LAST)
      burst_cnt_d = burst_cnt_q + CNT_W'(1);

    if (state_d == OWN0 && state_q != OWN0) last_d = 1'b0;
    if (state_d == OWN1 && state_q != OWN1) last_d = 1'b1;

    gnt0_d = (state_d == OWN0);
    gnt1_d = (state_d == OWN1);
  end

  // State registers; last starts at port 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port main memory; muxes the memory pins
// to the current owner and returns registered acks and read data.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_dout
);

  logic              accept0, accept1;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  rr_arb_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  // Reset gates the accept so no write can slip through during reset
  assign accept0 = gnt0 && req0 && !reset;
  assign accept1 = gnt1 && req1 && !reset;

  // Memory pin mux; idle cycles present a harmless read of address 0
  always_comb begin
    mem_rw   = MEM_READ;
    mem_addr = '0;
    mem_din  = '0;
    if (accept0) begin
      mem_rw   = rw0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end else if (accept1) begin
      mem_rw   = rw1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end
  end

  // Ack and read-data capture for the access accepted this cycle
  always_comb begin
    ack0_d   = accept0;
    ack1_d   = accept1;
    rdata0_d = (accept0 && rw0 == MEM_READ) ? mem_dout : rdata0_q;
    rdata1_d = (accept1 && rw1 == MEM_READ) ? mem_dout : rdata1_q;
  end

  // Response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level ownership model.
module tb_mem_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        reset, req0, req1, rw0, rw1;
  logic [7:0]  addr0, addr1, mem_addr;
  logic [15:0] wdata0, wdata1, mem_din, mem_dout, rdata0, rdata1;
  logic        gnt0, gnt1, ack0, ack1, mem_rw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rw(mem_rw), .mem_dout(mem_dout)
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 16) ? 16'hBEEF : 16'(i * 37 + 5);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory attached to the DUT pins
  logic [15:0] mem [256];
  assign mem_dout = mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_rw == 1'b0) mem[mem_addr] <= mem_din;
    end
  end

  // Reference model: who owns the memory, tie-break pointer, contested run length
  int          own;          // 0, 1, or 2 = nobody
  int          last_port;
  int          contest;
  bit          model_ok = 0;
  bit          e_ack0, e_ack1, e_rd0, e_rd1;
  logic [15:0] e_rdata0, e_rdata1;
  logic [15:0] ref_mem [256];

  initial begin
    bit r [2];
    int nxt, x, y, c;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (reset) begin
        own = 2; last_port = 1; contest = 0;
        e_ack0 = 0; e_ack1 = 0; e_rd0 = 0; e_rd1 = 0;
        e_rdata0 = 16'h0; e_rdata1 = 16'h0;
        model_ok = 1;
      end else if (model_ok) begin
        e_ack0 = (own == 0) && req0;
        e_ack1 = (own == 1) && req1;
        e_rd0  = e_ack0 && rw0;
        e_rd1  = e_ack1 && rw1;
        if (e_rd0) e_rdata0 = ref_mem[addr0];
        if (e_rd1) e_rdata1 = ref_mem[addr1];
        if (e_ack0 && !rw0) ref_mem[addr0] = wdata0;
        if (e_ack1 && !rw1) ref_mem[addr1] = wdata1;
        r[0] = req0; r[1] = req1;
        if (own == 2) begin
          if (r[0] && r[1]) nxt = 1 - last_port;
          else if (r[0])    nxt = 0;
          else if (r[1])    nxt = 1;
          else              nxt = 2;
          c = 0;
        end else begin
          x = own; y = 1 - own;
          c = r[y] ? contest + 1 : contest;
          if (!r[x])               nxt = r[y] ? y : 2;
          else if (r[y] && c >= MAXB) nxt = y;
          else                     nxt = x;
        end
        if (nxt != own) begin
          contest = 0;
          if (nxt != 2) last_port = nxt;
        end else begin
          contest = c;
        end
        own = nxt;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  initial begin
    bit a0, a1;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("gnt0", gnt0, own == 0);
        chk("gnt1", gnt1, own == 1);
        chk("gnt_both", gnt0 & gnt1, 0);
        chk("ack0", ack0, e_ack0);
        chk("ack1", ack1, e_ack1);
        if (e_rd0) chk("rdata0", rdata0, e_rdata0);
        if (e_rd1) chk("rdata1", rdata1, e_rdata1);
        a0 = (own == 0) && req0 && !reset;
        a1 = (own == 1) && req1 && !reset;
        chk("mem_rw",   mem_rw,   a0 ? rw0    : a1 ? rw1    : 1'b1);
        chk("mem_addr", mem_addr, a0 ? addr0  : a1 ? addr1  : 8'h0);
        chk("mem_din",  mem_din,  a0 ? wdata0 : a1 ? wdata1 : 16'h0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus with hand-computed expectations
  initial begin
    int n, k, match, na0, na1;
    reset = 1; req0 = 0; req1 = 0; rw0 = 1; rw1 = 1;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick(); tick();

    // Single read by port 0
    reset = 0; req0 = 1; rw0 = 1; addr0 = 8'h10;
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);   chk("rst_gnt1", gnt1, 0);
    chk("rst_ack0", ack0, 0);   chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0); chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_rw", mem_rw, 1); chk("rst_mem_addr", mem_addr, 0);
    tick(); @(negedge clk); chk("p1_gnt0", gnt0, 1);
    tick(); @(negedge clk);
    chk("p1_ack0", ack0, 1); chk("p1_rdata0", rdata0, 16'hBEEF); chk("p1_gnt1", gnt1, 0);
    tick(); req0 = 0;
    tick(); tick();

    // Port 1 writes then reads back
    req1 = 1; rw1 = 0; addr1 = 8'h20; wdata1 = 16'h1234;
    tick(); @(negedge clk); chk("p2_gnt1", gnt1, 1);
    tick(); addr1 = 8'h21; wdata1 = 16'h5678;
    @(negedge clk); chk("p2_ack_w0", ack1, 1);
    tick(); rw1 = 1; addr1 = 8'h20;
    @(negedge clk); chk("p2_ack_w1", ack1, 1); chk("p2_mem20", mem[8'h20], 16'h1234);
    tick(); addr1 = 8'h21;
    @(negedge clk); chk("p2_ack_r0", ack1, 1); chk("p2_rd20", rdata1, 16'h1234);
    tick(); req1 = 0;
    @(negedge clk); chk("p2_rd21", rdata1, 16'h5678);
    tick(); tick();

    // Simultaneous rise after reset, then handover without a gap
    reset = 1; tick(); reset = 0;
    req0 = 1; req1 = 1; rw0 = 1; rw1 = 1; addr0 = 8'h3; addr1 = 8'h4;
    tick(); @(negedge clk); chk("p3_gnt0_first", gnt0, 1); chk("p3_gnt1_off", gnt1, 0);
    tick(); req0 = 0;
    @(negedge clk); chk("p3_gnt0_visible", gnt0, 1);
    tick(); @(negedge clk); chk("p3_gnt1_next", gnt1, 1); chk("p3_gnt0_drop", gnt0, 0);
    tick(); req1 = 0;
    tick(); tick();

    // Continuous contention: runs of MAXB cycles per port
    req0 = 1; req1 = 1; addr0 = 8'h0; addr1 = 8'h1;
    tick();
    match = 0; na0 = 0; na1 = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (gnt0 === ((i / MAXB) % 2 == 0) && gnt1 === ((i / MAXB) % 2 == 1)) match++;
      if (i >= 1 && i <= 8 && ack0 === 1'b1)  na0++;
      if (i >= 9 && i <= 16 && ack1 === 1'b1) na1++;
    end
    chk("p4_run_pattern", match, 48);
    chk("p4_ack0_run", na0, 8);
    chk("p4_ack1_run", na1, 8);
    tick(); req0 = 0; req1 = 0;
    tick(); tick();

    // Uncontested owner keeps the grant; contender gets it after a full burst
    req0 = 1; addr0 = 8'h2;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt0 === 1'b1) n++;
    end
    chk("p5_hold20", n, 20);
    tick(); req1 = 1;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gnt1 === 1'b1) break;
      if (k < 11) tick();
    end
    chk("p5_wait_edges", k, MAXB);
    tick(); req0 = 0; req1 = 0;
    tick(); tick();

    // Reset during a port 1 write burst
    req1 = 1; rw1 = 0; addr1 = 8'h30; wdata1 = 16'hA000;
    tick(); addr1 = 8'h31; wdata1 = 16'hA001;
    tick(); addr1 = 8'h32; wdata1 = 16'hA002;
    tick(); reset = 1; addr1 = 8'h40; wdata1 = 16'hDEAD;
    @(negedge clk); chk("p6_rw_in_reset", mem_rw, 1);
    tick(); reset = 0;
    @(negedge clk);
    chk("p6_gnt0", gnt0, 0); chk("p6_gnt1", gnt1, 0);
    chk("p6_ack0", ack0, 0); chk("p6_ack1", ack1, 0);
    chk("p6_rdata0", rdata0, 0); chk("p6_rdata1", rdata1, 0);
    chk("p6_mem_rw", mem_rw, 1); chk("p6_mem_addr", mem_addr, 0);
    chk("p6_mem40", mem[8'h40], init_val(8'h40));
    tick(); req1 = 0;
    tick(); tick();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      rw0    = 1'($urandom_range(0, 1));
      rw1    = 1'($urandom_range(0, 1));
      addr0  = 8'($urandom_range(0, 15));
      addr1  = 8'($urandom_range(0, 15));
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
      reset  = ($urandom_range(0, 199) == 0);
    end
    tick(); reset = 0; req0 = 0; req1 = 0;
    tick(); tick();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
